// File: rtl/barrel_shift_decode_if.sv
// Handshake and data bundle between a requester and barrel_shift_decode.
interface barrel_shift_decode_if #(
    parameter int unsigned W = 8
);
    localparam int unsigned SW = $clog2(W);

    logic          start;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic          busy;
    logic          done;
    logic          found;
    logic [SW-1:0] shift;
    logic          lr;

    modport master (
        output start, x, y,
        input  busy, done, found, shift, lr
    );

    modport slave (
        input  start, x, y,
        output busy, done, found, shift, lr
    );
endinterface

// File: rtl/barrel_shift_decode.sv
// Recovers the (direction, amount) pair of a logical barrel shift that maps x onto y by
// walking the candidate list one entry per cycle. All outputs are registered and lag the
// FSM state by one cycle.
module barrel_shift_decode #(
    parameter int unsigned W = 8
) (
    input logic                   clk,
    input logic                   rst,
    barrel_shift_decode_if.slave  bus
);
    localparam int unsigned SW   = $clog2(W);
    localparam int unsigned NC   = 2 * W - 1;
    localparam int unsigned IW   = $clog2(NC);
    localparam logic [IW-1:0] LastIdx = IW'(NC - 1);

    typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  x_q, y_q;

    logic          res_found_q;
    logic          res_lr_q;
    logic [SW-1:0] res_shift_q;

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          found_q, found_d;
    logic          lr_q, lr_d;
    logic [SW-1:0] shift_q, shift_d;

    logic          accept;
    logic          cand_lr;
    logic [SW-1:0] cand_shift;
    logic [W-1:0]  cand_val;
    logic          match;
    logic          last;

    // busy_q still covers the done cycle (state already IDLE), so a start there is dropped.
    assign accept = (state_q == StIdle) && bus.start && !busy_q;

    // Map the index onto its candidate: left 0..W-1, then right 1..W-1.
    always_comb begin
        cand_lr    = 1'b0;
        cand_shift = idx_q[SW-1:0];
        if (idx_q >= IW'(W)) begin
            cand_lr    = 1'b1;
            cand_shift = SW'(idx_q - IW'(W - 1));
        end
        cand_val = cand_lr ? (x_q >> cand_shift) : (x_q << cand_shift);
        match    = (cand_val == y_q);
        last     = (idx_q == LastIdx);
    end

    // State and candidate index register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic: one candidate per SEARCH cycle, stop on first match or last index.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StSearch;
                    idx_d   = '0;
                end
            end
            StSearch: begin
                if (match || last) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Operand capture and search result latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q         <= '0;
            y_q         <= '0;
            res_found_q <= 1'b0;
            res_lr_q    <= 1'b0;
            res_shift_q <= '0;
        end else begin
            if (accept) begin
                x_q <= bus.x;
                y_q <= bus.y;
            end
            if ((state_q == StSearch) && (match || last)) begin
                res_found_q <= match;
                res_lr_q    <= match ? cand_lr : 1'b0;
                res_shift_q <= match ? cand_shift : '0;
            end
        end
    end

    // Output next values: result fields publish together with the done pulse, then hold.
    always_comb begin
        busy_d  = (state_q != StIdle);
        done_d  = (state_q == StDone);
        found_d = found_q;
        lr_d    = lr_q;
        shift_d = shift_q;
        if (state_q == StDone) begin
            found_d = res_found_q;
            lr_d    = res_lr_q;
            shift_d = res_shift_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            lr_q    <= 1'b0;
            shift_q <= '0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            found_q <= found_d;
            lr_q    <= lr_d;
            shift_q <= shift_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.found = found_q;
    assign bus.lr    = lr_q;
    assign bus.shift = shift_q;
endmodule

// File: tb/tb_barrel_shift_decode.sv
// Directed bench for barrel_shift_decode with a done-time scoreboard.
module tb_barrel_shift_decode;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        int         e;
        bit         f;
        bit         lr;
        logic [2:0] sh;
    } exp_t;

    exp_t sb[$];

    barrel_shift_decode_if #(.W(8)) bus ();

    barrel_shift_decode #(.W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Pop and compare whenever the DUT reports a result.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(bus.done), 0);
            end else begin
                e = sb.pop_front();
                check("done_edge", cyc, e.e);
                check("found", 32'(bus.found), 32'(e.f));
                check("lr", 32'(bus.lr), 32'(e.lr));
                check("shift", 32'(bus.shift), 32'(e.sh));
            end
        end
    end

    // Issue one request; k is the index of the expected first match (14 for no match).
    task automatic go(input logic [7:0] xv, input logic [7:0] yv, input int k,
                      input bit f, input bit l, input logic [2:0] s);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.x     = xv;
        bus.y     = yv;
        e.e  = cyc + 1 + k + 2;
        e.f  = f;
        e.lr = l;
        e.sh = s;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        // Scramble operands after capture; the search must not see these.
        bus.x = ~xv;
        bus.y = 8'($urandom);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(sb.size()), 0);
    endtask

    initial begin
        exp_t e;
        int   e0;
        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_found", 32'(bus.found), 0);
        check("rst_shift", 32'(bus.shift), 0);
        rst = 1'b0;

        // No match: busy window and done at edge 16.
        @(negedge clk);
        e0 = cyc + 1;
        bus.start = 1'b1;
        bus.x = 8'hB3;
        bus.y = 8'hFF;
        e.e = e0 + 16; e.f = 1'b0; e.lr = 1'b0; e.sh = 3'd0;
        sb.push_back(e);
        for (int j = 0; j <= 17; j++) begin
            @(negedge clk);
            if (j == 0) bus.start = 1'b0;
            check("busy_window", 32'(bus.busy), 32'((j >= 1 && j <= 16) ? 1 : 0));
        end
        wait_drain("timeout_nomatch");

        go(8'hB3, 8'h66, 1, 1'b1, 1'b0, 3'd1);
        wait_drain("timeout_b3_66");
        go(8'h00, 8'h00, 0, 1'b1, 1'b0, 3'd0);
        wait_drain("timeout_00_00");
        go(8'hB3, 8'h16, 10, 1'b1, 1'b1, 3'd3);
        wait_drain("timeout_b3_16");
        go(8'hFF, 8'h07, 12, 1'b1, 1'b1, 3'd5);
        wait_drain("timeout_ff_07");

        // Results hold while idle.
        repeat (3) @(negedge clk);
        check("hold_found", 32'(bus.found), 1);
        check("hold_lr", 32'(bus.lr), 1);
        check("hold_shift", 32'(bus.shift), 5);

        // Reset mid-search aborts without done; restart on first edge after release.
        @(negedge clk);
        e0 = cyc + 1;
        bus.start = 1'b1;
        bus.x = 8'hB3;
        bus.y = 8'hFF;
        e.e = e0 + 16; e.f = 1'b0; e.lr = 1'b0; e.sh = 3'd0;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_done", 32'(bus.done), 0);
        check("arst_found", 32'(bus.found), 0);
        check("arst_lr", 32'(bus.lr), 0);
        check("arst_shift", 32'(bus.shift), 0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        bus.start = 1'b1;
        bus.x = 8'h80;
        bus.y = 8'h00;
        e.e = cyc + 1 + 3; e.f = 1'b1; e.lr = 1'b0; e.sh = 3'd1;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain("timeout_after_rst");
        repeat (20) @(negedge clk);

        // start held high with operands changing: second start taken only after done.
        @(negedge clk);
        e0 = cyc + 1;
        bus.start = 1'b1;
        bus.x = 8'hB3;
        bus.y = 8'h66;
        e.e = e0 + 3; e.f = 1'b1; e.lr = 1'b0; e.sh = 3'd1;
        sb.push_back(e);
        e.e = e0 + 5 + 14; e.f = 1'b1; e.lr = 1'b1; e.sh = 3'd5;
        sb.push_back(e);
        @(negedge clk);
        bus.x = 8'hFF;
        bus.y = 8'h07;
        repeat (5) @(negedge clk);
        bus.start = 1'b0;
        wait_drain("timeout_held_start");
        repeat (20) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
